snitch_fpu_issue: RTL and testbench



---
 rtl/snitch_fpu_issue.sv | 137 +++++++++++++
 tb/tb_snitch_fpu_issue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_fpu_issue.sv
// FPU issue stage: RAW/WAW scoreboard, outstanding-op limit, tagged response steering
// to the FP register file or the integer core, and sticky fflags accumulation.
module snitch_fpu_issue #(
    parameter int unsigned FLEN           = 64,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // Core request
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [3*FLEN-1:0]   req_operands_i,
    input  logic [14:0]         req_rs_i,
    input  logic [2:0]          req_rs_used_i,
    input  logic [4:0]          req_rd_i,
    input  logic                req_rd_is_int_i,
    input  logic [2:0]          req_rnd_mode_i,
    input  logic [3:0]          req_op_i,
    input  logic                req_op_mod_i,
    input  logic [2:0]          req_src_fmt_i,
    input  logic [2:0]          req_dst_fmt_i,
    input  logic [1:0]          req_int_fmt_i,
    input  logic                req_vectorial_op_i,
    // FPU request
    output logic [3*FLEN-1:0]   fpu_operands_o,
    output logic [2:0]          fpu_rnd_mode_o,
    output logic [3:0]          fpu_op_o,
    output logic                fpu_op_mod_o,
    output logic [2:0]          fpu_src_fmt_o,
    output logic [2:0]          fpu_dst_fmt_o,
    output logic [1:0]          fpu_int_fmt_o,
    output logic                fpu_vectorial_op_o,
    output logic [5:0]          fpu_tag_o,
    output logic                fpu_in_valid_o,
    input  logic                fpu_in_ready_i,
    // FPU response
    input  logic [FLEN-1:0]     fpu_result_i,
    input  logic [4:0]          fpu_status_i,
    input  logic [5:0]          fpu_tag_i,
    input  logic                fpu_out_valid_i,
    output logic                fpu_out_ready_o,
    // FP register-file write port
    output logic                fpr_we_o,
    output logic [4:0]          fpr_waddr_o,
    output logic [FLEN-1:0]     fpr_wdata_o,
    // Integer response
    output logic                int_rsp_valid_o,
    input  logic                int_rsp_ready_i,
    output logic [FLEN-1:0]     int_rsp_data_o,
    output logic [4:0]          int_rsp_rd_o,
    // Status
    output logic [4:0]          fflags_o,
    input  logic                fflags_clr_i,
    output logic                busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [31:0]     r_sb;
    logic [CntW-1:0] r_cnt;
    logic [4:0]      r_fflags;

    logic [2:0]  w_src_pending;
    logic        w_raw;
    logic        w_waw;
    logic        w_full;
    logic        w_stall;
    logic        w_issue;
    logic        w_rsp_int;
    logic        w_rsp_hs;
    logic [31:0] w_sb_set;
    logic [31:0] w_sb_clr;

    // Hazard detection against registered scoreboard state only
    assign w_src_pending = {r_sb[req_rs_i[14:10]], r_sb[req_rs_i[9:5]], r_sb[req_rs_i[4:0]]};
    assign w_raw   = |(req_rs_used_i & w_src_pending);
    assign w_waw   = !req_rd_is_int_i && r_sb[req_rd_i];
    assign w_full  = (r_cnt == CntW'(MaxOutstanding));
    assign w_stall = w_raw || w_waw || w_full;

    assign fpu_in_valid_o = req_valid_i && !w_stall;
    assign req_ready_o    = fpu_in_ready_i && !w_stall;
    assign w_issue        = fpu_in_valid_o && fpu_in_ready_i;

    assign fpu_operands_o     = req_operands_i;
    assign fpu_rnd_mode_o     = req_rnd_mode_i;
    assign fpu_op_o           = req_op_i;
    assign fpu_op_mod_o       = req_op_mod_i;
    assign fpu_src_fmt_o      = req_src_fmt_i;
    assign fpu_dst_fmt_o      = req_dst_fmt_i;
    assign fpu_int_fmt_o      = req_int_fmt_i;
    assign fpu_vectorial_op_o = req_vectorial_op_i;
    assign fpu_tag_o          = {req_rd_is_int_i, req_rd_i};

    // Tag bit 5 selects the integer path; the FP write port never backpressures
    assign w_rsp_int       = fpu_tag_i[5];
    assign fpu_out_ready_o = w_rsp_int ? int_rsp_ready_i : 1'b1;
    assign w_rsp_hs        = fpu_out_valid_i && fpu_out_ready_o;

    assign fpr_we_o        = fpu_out_valid_i && !w_rsp_int;
    assign fpr_waddr_o     = fpu_tag_i[4:0];
    assign fpr_wdata_o     = fpu_result_i;
    assign int_rsp_valid_o = fpu_out_valid_i && w_rsp_int;
    assign int_rsp_data_o  = fpu_result_i;
    assign int_rsp_rd_o    = fpu_tag_i[4:0];

    assign w_sb_set = (w_issue && !req_rd_is_int_i) ? (32'd1 << req_rd_i) : 32'd0;
    assign w_sb_clr = (w_rsp_hs && !w_rsp_int) ? (32'd1 << fpu_tag_i[4:0]) : 32'd0;

    assign fflags_o = r_fflags;
    assign busy_o   = (r_cnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sb     <= '0;
            r_cnt    <= '0;
            r_fflags <= '0;
        end else begin
            r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
            if (w_issue && !w_rsp_hs) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_issue && w_rsp_hs) begin
                r_cnt <= r_cnt - CntW'(1);
            end
            // Clear takes effect before the new flags are merged in
            if (fflags_clr_i) begin
                r_fflags <= w_rsp_hs ? fpu_status_i : 5'd0;
            end else if (w_rsp_hs) begin
                r_fflags <= r_fflags | fpu_status_i;
            end
        end
    end

    a_rsp_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fpu_out_valid_i && !fpu_tag_i[5]) |-> r_sb[fpu_tag_i[4:0]]);

endmodule

// File: tb/tb_snitch_fpu_issue.sv
// Directed bench for snitch_fpu_issue: combinational vector table against a fixed
// scoreboard state, plus hand-written multi-cycle sequences.
module tb_snitch_fpu_issue;

    localparam int unsigned FLEN = 64;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [3*FLEN-1:0] req_operands_i;
    logic [14:0]       req_rs_i;
    logic [2:0]        req_rs_used_i;
    logic [4:0]        req_rd_i;
    logic              req_rd_is_int_i;
    logic [2:0]        req_rnd_mode_i;
    logic [3:0]        req_op_i;
    logic              req_op_mod_i;
    logic [2:0]        req_src_fmt_i;
    logic [2:0]        req_dst_fmt_i;
    logic [1:0]        req_int_fmt_i;
    logic              req_vectorial_op_i;
    logic [3*FLEN-1:0] fpu_operands_o;
    logic [2:0]        fpu_rnd_mode_o;
    logic [3:0]        fpu_op_o;
    logic              fpu_op_mod_o;
    logic [2:0]        fpu_src_fmt_o;
    logic [2:0]        fpu_dst_fmt_o;
    logic [1:0]        fpu_int_fmt_o;
    logic              fpu_vectorial_op_o;
    logic [5:0]        fpu_tag_o;
    logic              fpu_in_valid_o;
    logic              fpu_in_ready_i;
    logic [FLEN-1:0]   fpu_result_i;
    logic [4:0]        fpu_status_i;
    logic [5:0]        fpu_tag_i;
    logic              fpu_out_valid_i;
    logic              fpu_out_ready_o;
    logic              fpr_we_o;
    logic [4:0]        fpr_waddr_o;
    logic [FLEN-1:0]   fpr_wdata_o;
    logic              int_rsp_valid_o;
    logic              int_rsp_ready_i;
    logic [FLEN-1:0]   int_rsp_data_o;
    logic [4:0]        int_rsp_rd_o;
    logic [4:0]        fflags_o;
    logic              fflags_clr_i;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;

    snitch_fpu_issue #(.FLEN(FLEN), .MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operands_i(req_operands_i), .req_rs_i(req_rs_i),
        .req_rs_used_i(req_rs_used_i), .req_rd_i(req_rd_i),
        .req_rd_is_int_i(req_rd_is_int_i), .req_rnd_mode_i(req_rnd_mode_i),
        .req_op_i(req_op_i), .req_op_mod_i(req_op_mod_i),
        .req_src_fmt_i(req_src_fmt_i), .req_dst_fmt_i(req_dst_fmt_i),
        .req_int_fmt_i(req_int_fmt_i), .req_vectorial_op_i(req_vectorial_op_i),
        .fpu_operands_o(fpu_operands_o), .fpu_rnd_mode_o(fpu_rnd_mode_o),
        .fpu_op_o(fpu_op_o), .fpu_op_mod_o(fpu_op_mod_o),
        .fpu_src_fmt_o(fpu_src_fmt_o), .fpu_dst_fmt_o(fpu_dst_fmt_o),
        .fpu_int_fmt_o(fpu_int_fmt_o), .fpu_vectorial_op_o(fpu_vectorial_op_o),
        .fpu_tag_o(fpu_tag_o), .fpu_in_valid_o(fpu_in_valid_o),
        .fpu_in_ready_i(fpu_in_ready_i), .fpu_result_i(fpu_result_i),
        .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
        .int_rsp_valid_o(int_rsp_valid_o), .int_rsp_ready_i(int_rsp_ready_i),
        .int_rsp_data_o(int_rsp_data_o), .int_rsp_rd_o(int_rsp_rd_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req_valid;
        logic [14:0] rs;
        logic [2:0]  rs_used;
        logic [4:0]  rd;
        logic        rd_is_int;
        logic        in_ready;
        logic        out_valid;
        logic [5:0]  tag;
        logic        int_ready;
        logic        exp_req_ready;
        logic        exp_in_valid;
        logic        exp_out_ready;
        logic        exp_fpr_we;
        logic        exp_int_valid;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        req_valid_i     = 1'b0;
        req_rs_i        = '0;
        req_rs_used_i   = '0;
        req_rd_i        = '0;
        req_rd_is_int_i = 1'b0;
        fpu_in_ready_i  = 1'b0;
        fpu_out_valid_i = 1'b0;
        fpu_tag_i       = '0;
        fpu_result_i    = '0;
        fpu_status_i    = '0;
        int_rsp_ready_i = 1'b0;
        fflags_clr_i    = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk_i);
        idle();
    endtask

    task automatic req(input logic [4:0] rd, input logic is_int,
                       input logic [14:0] rs, input logic [2:0] used);
        req_valid_i     = 1'b1;
        fpu_in_ready_i  = 1'b1;
        req_rd_i        = rd;
        req_rd_is_int_i = is_int;
        req_rs_i        = rs;
        req_rs_used_i   = used;
    endtask

    task automatic rsp(input logic [5:0] tag, input logic [4:0] status, input logic [63:0] res);
        fpu_out_valid_i = 1'b1;
        fpu_tag_i       = tag;
        fpu_status_i    = status;
        fpu_result_i    = res;
        int_rsp_ready_i = 1'b1;
    endtask

    initial begin
        // State while applying the table: sb[3] pending, one op outstanding (limit 2)
        vecs[0]  = '{1, 15'h0003, 3'b001, 5'd4, 0, 1, 0, 6'h00, 0,  0, 0, 1, 0, 0};
        vecs[1]  = '{1, 15'h0003, 3'b000, 5'd4, 0, 1, 0, 6'h00, 0,  1, 1, 1, 0, 0};
        vecs[2]  = '{1, 15'h0060, 3'b010, 5'd4, 0, 1, 0, 6'h00, 0,  0, 0, 1, 0, 0};
        vecs[3]  = '{1, 15'h0C00, 3'b100, 5'd4, 0, 1, 0, 6'h00, 0,  0, 0, 1, 0, 0};
        vecs[4]  = '{1, 15'h0C00, 3'b011, 5'd4, 0, 1, 0, 6'h00, 0,  1, 1, 1, 0, 0};
        vecs[5]  = '{1, 15'h0000, 3'b000, 5'd3, 0, 1, 0, 6'h00, 0,  0, 0, 1, 0, 0};
        vecs[6]  = '{1, 15'h0000, 3'b000, 5'd3, 1, 0, 0, 6'h00, 0,  0, 1, 1, 0, 0};
        vecs[7]  = '{0, 15'h0000, 3'b000, 5'd4, 0, 1, 0, 6'h00, 0,  1, 0, 1, 0, 0};
        vecs[8]  = '{0, 15'h0000, 3'b000, 5'd4, 0, 1, 1, 6'h03, 0,  1, 0, 1, 1, 0};
        vecs[9]  = '{0, 15'h0000, 3'b000, 5'd4, 0, 1, 1, 6'h25, 0,  1, 0, 0, 0, 1};
        vecs[10] = '{0, 15'h0000, 3'b000, 5'd4, 0, 1, 1, 6'h25, 1,  1, 0, 1, 0, 1};

        req_operands_i = '0;
        req_rnd_mode_i = '0;
        req_op_i = '0; req_op_mod_i = 1'b0;
        req_src_fmt_i = '0; req_dst_fmt_i = '0; req_int_fmt_i = '0;
        req_vectorial_op_i = 1'b0;
        idle();
        rst_ni = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", 192'(busy_o), 192'(0));
        chk("rst_fflags", 192'(fflags_o), 192'(0));
        chk("rst_fpr_we", 192'(fpr_we_o), 192'(0));
        chk("rst_int_valid", 192'(int_rsp_valid_o), 192'(0));
        chk("rst_in_valid", 192'(fpu_in_valid_o), 192'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Independent ops with a one-cycle FPU
        cyc(); req(5'd1, 1'b0, '0, '0);
        req_operands_i = 192'h0123_4567_89AB_CDEF_1111_2222_3333_4444_5555_6666_7777_8888;
        req_rnd_mode_i = 3'b010;
        #1;
        chk("a_ready1", 192'(req_ready_o), 192'(1));
        chk("a_valid1", 192'(fpu_in_valid_o), 192'(1));
        chk("a_tag1", 192'(fpu_tag_o), 192'(6'h01));
        chk("a_operands", fpu_operands_o, 192'h0123_4567_89AB_CDEF_1111_2222_3333_4444_5555_6666_7777_8888);
        chk("a_rnd", 192'(fpu_rnd_mode_o), 192'(3'b010));
        cyc(); req(5'd2, 1'b0, '0, '0); rsp(6'h01, 5'd0, 64'h1111); #1;
        chk("a_ready2", 192'(req_ready_o), 192'(1));
        chk("a_we1", 192'(fpr_we_o), 192'(1));
        chk("a_waddr1", 192'(fpr_waddr_o), 192'(1));
        chk("a_wdata1", 192'(fpr_wdata_o), 192'(64'h1111));
        chk("a_busy", 192'(busy_o), 192'(1));
        cyc(); rsp(6'h02, 5'd0, 64'h2222); #1;
        chk("a_we2", 192'(fpr_we_o), 192'(1));
        chk("a_waddr2", 192'(fpr_waddr_o), 192'(2));
        chk("a_busy_same_cycle", 192'(busy_o), 192'(1));
        cyc(); #1;
        chk("a_idle_busy", 192'(busy_o), 192'(0));
        chk("a_idle_we", 192'(fpr_we_o), 192'(0));

        // Make f3 pending, then sweep the combinational table
        cyc(); req(5'd3, 1'b0, '0, '0); #1;
        chk("b_issue3", 192'(req_ready_o), 192'(1));
        cyc(); #1;
        chk("b_busy", 192'(busy_o), 192'(1));
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_i);
            idle();
            req_valid_i     = vecs[i].req_valid;
            req_rs_i        = vecs[i].rs;
            req_rs_used_i   = vecs[i].rs_used;
            req_rd_i        = vecs[i].rd;
            req_rd_is_int_i = vecs[i].rd_is_int;
            fpu_in_ready_i  = vecs[i].in_ready;
            fpu_out_valid_i = vecs[i].out_valid;
            fpu_tag_i       = vecs[i].tag;
            int_rsp_ready_i = vecs[i].int_ready;
            #1;
            chk($sformatf("v%0d_req_ready", i), 192'(req_ready_o), 192'(vecs[i].exp_req_ready));
            chk($sformatf("v%0d_in_valid", i), 192'(fpu_in_valid_o), 192'(vecs[i].exp_in_valid));
            chk($sformatf("v%0d_out_ready", i), 192'(fpu_out_ready_o), 192'(vecs[i].exp_out_ready));
            chk($sformatf("v%0d_fpr_we", i), 192'(fpr_we_o), 192'(vecs[i].exp_fpr_we));
            chk($sformatf("v%0d_int_valid", i), 192'(int_rsp_valid_o), 192'(vecs[i].exp_int_valid));
            #1;
            idle();
        end

        // RAW on f3: stalled through the writeback cycle, issues the cycle after
        for (int i = 0; i < 3; i++) begin
            cyc(); req(5'd8, 1'b0, 15'd3, 3'b001); #1;
            chk("raw_stall", 192'(req_ready_o), 192'(0));
        end
        cyc(); req(5'd8, 1'b0, 15'd3, 3'b001); rsp(6'h03, 5'd0, 64'h3333); #1;
        chk("raw_no_bypass", 192'(req_ready_o), 192'(0));
        chk("raw_wb3", 192'(fpr_we_o), 192'(1));
        cyc(); req(5'd8, 1'b0, 15'd3, 3'b001); #1;
        chk("raw_issue", 192'(req_ready_o), 192'(1));
        cyc(); rsp(6'h08, 5'd0, 64'h8888); #1;
        chk("raw_waddr8", 192'(fpr_waddr_o), 192'(8));
        cyc(); #1;
        chk("raw_done", 192'(busy_o), 192'(0));

        // Full at two outstanding, then WAW on f5
        cyc(); req(5'd4, 1'b0, '0, '0); #1;
        chk("c_issue4", 192'(req_ready_o), 192'(1));
        cyc(); req(5'd5, 1'b0, '0, '0); #1;
        chk("c_issue5", 192'(req_ready_o), 192'(1));
        for (int i = 0; i < 2; i++) begin
            cyc(); req(5'd6, 1'b0, '0, '0); #1;
            chk("c_full_ready", 192'(req_ready_o), 192'(0));
            chk("c_full_valid", 192'(fpu_in_valid_o), 192'(0));
        end
        cyc(); req(5'd6, 1'b0, '0, '0); rsp(6'h04, 5'd0, 64'h4444); #1;
        chk("c_full_rsp", 192'(req_ready_o), 192'(0));
        cyc(); req(5'd6, 1'b0, '0, '0); #1;
        chk("c_issue6", 192'(req_ready_o), 192'(1));
        cyc(); req(5'd5, 1'b0, '0, '0); rsp(6'h06, 5'd0, 64'h6666); #1;
        chk("c_waw_full", 192'(req_ready_o), 192'(0));
        cyc(); req(5'd5, 1'b0, '0, '0); #1;
        chk("c_waw", 192'(req_ready_o), 192'(0));
        cyc(); req(5'd5, 1'b0, '0, '0); rsp(6'h05, 5'd0, 64'h5555); #1;
        chk("c_waw_wb", 192'(req_ready_o), 192'(0));
        cyc(); req(5'd5, 1'b0, '0, '0); #1;
        chk("c_waw_issue", 192'(req_ready_o), 192'(1));
        cyc(); rsp(6'h05, 5'd0, 64'h5555); #1;
        chk("c_wb5", 192'(fpr_we_o), 192'(1));
        cyc(); #1;
        chk("c_done", 192'(busy_o), 192'(0));

        // Integer destination with backpressure
        cyc(); req(5'd5, 1'b1, '0, '0); #1;
        chk("d_tag", 192'(fpu_tag_o), 192'(6'h25));
        for (int i = 0; i < 3; i++) begin
            cyc(); rsp(6'h25, 5'd0, 64'hDEAD); int_rsp_ready_i = 1'b0; #1;
            chk("d_int_valid", 192'(int_rsp_valid_o), 192'(1));
            chk("d_out_ready", 192'(fpu_out_ready_o), 192'(0));
            chk("d_no_fpr_we", 192'(fpr_we_o), 192'(0));
            chk("d_int_rd", 192'(int_rsp_rd_o), 192'(5));
            chk("d_int_data", 192'(int_rsp_data_o), 192'(64'hDEAD));
            chk("d_busy_held", 192'(busy_o), 192'(1));
        end
        cyc(); rsp(6'h25, 5'd0, 64'hDEAD); #1;
        chk("d_accept", 192'(fpu_out_ready_o), 192'(1));
        cyc(); #1;
        chk("d_done", 192'(busy_o), 192'(0));

        // Sticky flags and clear-with-response
        cyc(); req(5'd1, 1'b1, '0, '0);
        cyc(); req(5'd2, 1'b1, '0, '0);
        cyc(); rsp(6'h21, 5'b00001, 64'h1);
        cyc(); rsp(6'h22, 5'b10000, 64'h2);
        cyc(); #1;
        chk("e_fflags_or", 192'(fflags_o), 192'(5'b10001));
        chk("e_busy", 192'(busy_o), 192'(0));
        cyc(); req(5'd3, 1'b1, '0, '0);
        cyc(); rsp(6'h23, 5'b00100, 64'h3); fflags_clr_i = 1'b1;
        cyc(); #1;
        chk("e_fflags_clr", 192'(fflags_o), 192'(5'b00100));

        // Asynchronous reset with ops in flight
        cyc(); req(5'd10, 1'b0, '0, '0);
        cyc(); req(5'd11, 1'b0, '0, '0);
        cyc(); #1;
        chk("f_busy_pre", 192'(busy_o), 192'(1));
        chk("f_fflags_pre", 192'(fflags_o), 192'(5'b00100));
        #1;
        rst_ni = 1'b0;
        #1;
        chk("f_busy_rst", 192'(busy_o), 192'(0));
        chk("f_fflags_rst", 192'(fflags_o), 192'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
        req(5'd12, 1'b0, 15'd10, 3'b001); #1;
        chk("f_sb_cleared", 192'(req_ready_o), 192'(1));
        cyc(); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
